// File: rtl/ddr_model_fifo.sv
// Single-clock 64-bit reply FIFO for the DDR3 app-interface behavioural model.
// Latency: dout is valid the cycle after an accepted rd_en; flags update on the same edge as the operation.
// Backpressure: writes while full and reads while empty are dropped; each drop raises a one-cycle overflow/underflow pulse.
`timescale 1ns/1ps
module ddr_model_fifo #(
    parameter int pDATA_WIDTH       = 64,
    parameter int pDEPTH            = 32,
    parameter int pPROG_FULL_THRESH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [pDATA_WIDTH-1:0] din,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [pDATA_WIDTH-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic                   prog_full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(pDEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(pDEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(pPROG_FULL_THRESH);

    logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            count_q, count_d;
    logic [pDATA_WIDTH-1:0] dout_q;
    logic                   empty_q, full_q, prog_full_q;
    logic                   overflow_q, underflow_q;
    logic                   wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a read never frees space for a same-cycle write and vice versa.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    // Occupancy next state: simultaneous accepted read and write cancel out.
    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage array; contents are intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers, count, registered read data and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            prog_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem_q[rd_ptr_q];
            end
            count_q     <= count_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == DEPTH_C);
            prog_full_q <= (count_d >= THRESH_C);
            overflow_q  <= wr_en & full_q;
            underflow_q <= rd_en & empty_q;
        end
    end

    assign dout      = dout_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign prog_full = prog_full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_ddr_model_fifo.sv
// Directed bench for ddr_model_fifo: ordering, flags, error pulses and async reset.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point (post-edge state).
// Expected values are hand-derived constants; no DUT readback is used for expectations.
`timescale 1ns/1ps
module tb_ddr_model_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] din = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [63:0] dout;
    logic        full, empty, prog_full, overflow, underflow;

    int n_vec = 0;
    int n_err = 0;

    ddr_model_fifo #(
        .pDATA_WIDTH(64), .pDEPTH(32), .pPROG_FULL_THRESH(16)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .full(full), .empty(empty), .prog_full(prog_full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d);
        wr_en = 1'b1;
        din   = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        logic [63:0] base;
        base = 64'h0000_0001_0000_0000;

        // 1: reset then idle
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_pfull", {63'd0, prog_full}, 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_udf", {63'd0, underflow}, 64'd0);

        // 2: three words, read with gap cycles
        for (int i = 0; i < 3; i++) push(base + 64'(i));
        chk("t2_not_empty", {63'd0, empty}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            pop();
            chk("t2_dout", dout, base + 64'(i));
            tick();
            chk("t2_hold", dout, base + 64'(i));
        end
        chk("t2_empty", {63'd0, empty}, 64'd1);

        // 3: prog_full threshold
        for (int i = 0; i < 15; i++) push(64'h200 + 64'(i));
        chk("t3_pf15", {63'd0, prog_full}, 64'd0);
        push(64'h20F);
        chk("t3_pf16", {63'd0, prog_full}, 64'd1);
        pop();
        chk("t3_pf_drop", {63'd0, prog_full}, 64'd0);
        chk("t3_dout", dout, 64'h200);
        for (int i = 1; i < 16; i++) pop();
        chk("t3_last", dout, 64'h20F);
        chk("t3_empty", {63'd0, empty}, 64'd1);

        // 4: fill, overflow, drain
        for (int i = 0; i < 32; i++) push(64'h100 + 64'(i));
        chk("t4_full", {63'd0, full}, 64'd1);
        chk("t4_no_ovf", {63'd0, overflow}, 64'd0);
        push(64'hDEAD);
        chk("t4_ovf", {63'd0, overflow}, 64'd1);
        chk("t4_still_full", {63'd0, full}, 64'd1);
        tick();
        chk("t4_ovf_pulse", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            pop();
            chk("t4_drain", dout, 64'h100 + 64'(i));
            if (i == 0) chk("t4_not_full", {63'd0, full}, 64'd0);
        end
        chk("t4_empty", {63'd0, empty}, 64'd1);
        chk("t4_no_udf", {63'd0, underflow}, 64'd0);

        // 5: underflow, then simultaneous write+read while empty
        pop();
        chk("t5_udf", {63'd0, underflow}, 64'd1);
        chk("t5_dout_hold", dout, 64'h11F);
        tick();
        chk("t5_udf_pulse", {63'd0, underflow}, 64'd0);
        wr_en = 1'b1; rd_en = 1'b1; din = 64'h55;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("t5_udf2", {63'd0, underflow}, 64'd1);
        chk("t5_count1", {63'd0, empty}, 64'd0);
        chk("t5_dout_hold2", dout, 64'h11F);
        pop();
        chk("t5_dout", dout, 64'h55);
        chk("t5_empty", {63'd0, empty}, 64'd1);

        // 6: async reset mid-stream
        for (int i = 0; i < 20; i++) push(64'h300 + 64'(i));
        chk("t6_pf_before", {63'd0, prog_full}, 64'd1);
        pop();
        chk("t6_dout_before", dout, 64'h300);
        wr_en = 1'b1; din = 64'h3FF;
        #2 rst = 1'b0;
        #1;
        chk("t6_arst_empty", {63'd0, empty}, 64'd1);
        chk("t6_arst_pf", {63'd0, prog_full}, 64'd0);
        chk("t6_arst_dout", dout, 64'd0);
        wr_en = 1'b0;
        tick();
        #3 rst = 1'b1;
        tick();
        push(64'hBEEF);
        chk("t6_one", {63'd0, empty}, 64'd0);
        pop();
        chk("t6_dout", dout, 64'hBEEF);
        chk("t6_empty", {63'd0, empty}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
